store_unit: RTL and testbench
=============================

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL provide parameter ACK_TIMEOUT, default 256, max cycles in WAIT_ACK before abort (legal range 1..65535).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  async active-low reset.
REQ-005 st_valid  input  1  pipeline presents a store.
REQ-006 st_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 st_addr  input  32  byte address.
REQ-008 st_data  input  32  register data, value in low bits.
REQ-009 st_ready  output  1  unit accepts store this cycle.
REQ-010 mem_req  output  1  write request to data memory.
REQ-011 mem_addr  output  32  word address, bits [1:0] always 0.
REQ-012 mem_wdata  output  32  lane-replicated write data.
REQ-013 mem_be  output  4  byte enables, bit i = byte lane i.
REQ-014 mem_ack  input  1  memory write complete.
REQ-015 done  output  1  one-cycle pulse, store completed.
REQ-016 align_err  output  1  one-cycle pulse, store rejected as misaligned/reserved.
REQ-017 timeout_err  output  1  one-cycle pulse, store aborted on timeout.

Function
REQ-018 SHALL implement states IDLE and WAIT_ACK; st_ready = (state==IDLE), combinational.
REQ-019 Accept = st_valid & st_ready at rising edge; legal accepted store -> WAIT_ACK next cycle, mem_req high from that cycle.
REQ-020 mem_addr/mem_wdata/mem_be SHALL be registered at accept and held stable while mem_req high.
REQ-021 Byte: wdata = data[7:0] replicated ×4; be = 1 << addr[1:0].
REQ-022 Half: wdata = data[15:0] replicated ×2; be = 0011 if addr[1]=0, else 1100.
REQ-023 Word: wdata = data; be = 1111.
REQ-024 Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size 11: accepted, no mem_req, align_err pulses next cycle, state stays IDLE.
REQ-025 In WAIT_ACK, mem_ack high -> IDLE next cycle, mem_req low, done pulse that cycle; min throughput one store per 2 cycles.
REQ-026 mem_ack outside WAIT_ACK SHALL be ignored.
REQ-027 16-bit wait counter cleared on entry to WAIT_ACK, incremented each WAIT_ACK cycle without ack.
REQ-028 Counter reaching ACK_TIMEOUT -> IDLE, mem_req low, timeout_err pulse; ack in that same cycle wins (done, no timeout_err).
REQ-029 done, align_err, timeout_err SHALL be mutually exclusive.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, mem_req/done/align_err/timeout_err 0, mem_addr/mem_wdata 0, mem_be 0000, counter 0.
REQ-031 Reset during WAIT_ACK SHALL abandon the store with no pulse; st_ready high first cycle after release.

Structure
REQ-032 Shared package mips_pkg SHALL hold st_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-033 Combinational sub-module store_lane_align (size, addr[1:0], data -> wdata, be, misaligned); store_unit holds FSM, registers, counter.

Verification
REQ-034 Byte store addr 0x1003 data 0x000000AB, ack 2 cycles later -> mem_addr 0x1000, wdata 0xABABABAB, be 1000, done once.
REQ-035 Half store addr 0x2002 data 0x1234BEEF -> wdata 0xBEEFBEEF, be 1100; half at 0x2001 -> align_err, no mem_req.
REQ-036 Word store addr 0x3000 data 0xDEADBEEF, ack held high continuously -> one done per 2 cycles, back-to-back stores.
REQ-037 ACK_TIMEOUT=4, no ack -> mem_req high 4 cycles, then timeout_err, IDLE; rerun with ack on 4th cycle -> done only.
REQ-038 rst_n low mid-WAIT_ACK -> mem_req 0 same cycle, no pulses; size 11 store -> align_err.

Source files
------------

// File: rtl/mips_pkg.sv
// Store-path encodings shared by the store unit and its lane aligner.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Maps a store (size, low address bits, register data) onto 32-bit memory byte lanes.
module store_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o
);

    always_comb begin
        wdata_o      = data_i;
        be_o         = 4'b0000;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
            end
            SZ_HALF: begin
                wdata_o      = {2{data_i[15:0]}};
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            // Reserved size is rejected the same way as a misaligned store.
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time, issues a data-memory write and waits for ack or timeout.
module store_unit
    import mips_pkg::*;
#(
    parameter int ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        done,
    output logic        align_err,
    output logic        timeout_err
);

    // Counter value seen in the last WAIT_ACK cycle that may still receive an ack.
    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    st_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        aerr_q, aerr_d;
    logic        terr_q, terr_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        lane_misaligned;

    store_lane_align u_align (
        .size_i       (st_size),
        .addr_lo_i    (st_addr[1:0]),
        .data_i       (st_data),
        .wdata_o      (lane_wdata),
        .be_o         (lane_be),
        .misaligned_o (lane_misaligned)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        aerr_d  = 1'b0;
        terr_d  = 1'b0;
        if (state_q == IDLE) begin
            if (st_valid) begin
                if (lane_misaligned) begin
                    aerr_d = 1'b1;
                end else begin
                    state_d = WAIT_ACK;
                    addr_d  = {st_addr[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    be_d    = lane_be;
                    cnt_d   = '0;
                end
            end
        end else begin
            // An ack arriving in the final allowed cycle takes priority over the timeout.
            if (mem_ack) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                terr_d  = 1'b1;
                cnt_d   = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            terr_q  <= terr_d;
        end
    end

    assign st_ready    = (state_q == IDLE);
    assign mem_req     = (state_q == WAIT_ACK);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_be      = be_q;
    assign done        = done_q;
    assign align_err   = aerr_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: directed scenarios plus randomized stores against a transaction model.
module tb_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [1:0]  st_size = 2'b00;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        mem_ack = 1'b0;
    logic        st_ready, mem_req, done, align_err, timeout_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    store_unit #(.ACK_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_size     (st_size),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .done        (done),
        .align_err   (align_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // {mem_req, st_ready, done, align_err, timeout_err}
    assign flags = {mem_req, st_ready, done, align_err, timeout_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one store from IDLE; ack_at = WAIT_ACK cycle (1-based) carrying mem_ack, 0 = never.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input int ack_at, input string nm);
        int          nbytes;
        logic        legal, acked;
        logic [31:0] mask, rep, ew, ea;
        logic [3:0]  eb;
        logic [4:0]  ef;
        nbytes = (sz == 2'd3) ? 0 : (1 << sz);
        legal  = (nbytes != 0) && ((a % nbytes) == 0);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        rep    = (nbytes == 1) ? 32'h0101_0101 : (nbytes == 2) ? 32'h0001_0001 : 32'd1;
        ew     = (d & mask) * rep;
        eb     = 4'(((1 << nbytes) - 1) << (a % 4));
        ea     = a - (a % 4);
        total++;
        if (st_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready: got %b want 1", nm, st_ready);
        end
        st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
        tick();
        st_valid = 1'b0; st_size = 2'($urandom); st_addr = $urandom; st_data = $urandom;
        if (!legal) begin
            total++;
            if (flags !== 5'b01010) begin
                bad++;
                $display("FAIL %s align: flags got %b want 01010", nm, flags);
            end
            return;
        end
        acked = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            total++;
            if ({flags, mem_addr, mem_wdata, mem_be} !== {5'b10000, ea, ew, eb}) begin
                bad++;
                $display("FAIL %s wait%0d: got %b %h %h %b want %b %h %h %b", nm, k,
                         flags, mem_addr, mem_wdata, mem_be, 5'b10000, ea, ew, eb);
            end
            mem_ack = (k == ack_at);
            acked   = mem_ack;
            tick();
            mem_ack = 1'b0;
            if (acked) break;
        end
        ef = acked ? 5'b01100 : 5'b01001;
        total++;
        if (flags !== ef) begin
            bad++;
            $display("FAIL %s end: flags got %b want %b", nm, flags, ef);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({flags, mem_addr, mem_wdata, mem_be} !== {5'b01000, 68'd0}) begin
            bad++;
            $display("FAIL reset: got %b %h %h %b want 01000 0 0 0", flags, mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (flags !== 5'b01000) begin
            bad++;
            $display("FAIL reset_release: flags got %b want 01000", flags);
        end
    endtask

    task automatic test_byte();
        do_store(2'b00, 32'h0000_1003, 32'h0000_00AB, 2, "byte");
        tick();
        total++;
        if (flags !== 5'b01000) begin
            bad++;
            $display("FAIL byte_once: flags got %b want 01000", flags);
        end
    endtask

    task automatic test_half();
        do_store(2'b01, 32'h0000_2002, 32'h1234_BEEF, 1, "half");
        do_store(2'b01, 32'h0000_2001, 32'h1234_BEEF, 1, "half_mis");
        do_store(2'b10, 32'h0000_2002, 32'h1234_BEEF, 1, "word_mis");
        do_store(2'b11, 32'h0000_2000, 32'h1234_BEEF, 1, "reserved");
        tick();
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (flags !== 5'b01000) begin
                bad++;
                $display("FAIL ack_idle%0d: flags got %b want 01000", i, flags);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a;
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? 32'hDEAD_BEEF : $urandom;
            a = 32'h0000_3000 + 32'(4 * i);
            total++;
            if (flags !== {2'b01, (i > 0), 2'b00}) begin
                bad++;
                $display("FAIL b2b_idle%0d: flags got %b want %b", i, flags, {2'b01, (i > 0), 2'b00});
            end
            st_valid = 1'b1; st_size = 2'b10; st_addr = a; st_data = d;
            tick();
            total++;
            if ({flags, mem_addr, mem_wdata, mem_be} !== {5'b10000, a, d, 4'hF}) begin
                bad++;
                $display("FAIL b2b_wait%0d: got %b %h %h %b want 10000 %h %h 1111", i,
                         flags, mem_addr, mem_wdata, mem_be, a, d);
            end
            tick();
        end
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        total++;
        if (flags !== 5'b01100) begin
            bad++;
            $display("FAIL b2b_last: flags got %b want 01100", flags);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_store(2'b10, 32'h0000_4000, 32'h0BAD_F00D, 0, "timeout");
        tick();
        do_store(2'b10, 32'h0000_4004, 32'hCAFE_0001, TO, "ack_last");
        tick();
    endtask

    task automatic test_reset_mid();
        st_valid = 1'b1; st_size = 2'b10; st_addr = 32'h0000_5000; st_data = 32'h5555_AAAA;
        tick();
        st_valid = 1'b0;
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rmid_req: mem_req got %b want 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({flags, mem_addr, mem_wdata, mem_be} !== {5'b01000, 68'd0}) begin
            bad++;
            $display("FAIL rmid_async: got %b %h %h %b want 01000 0 0 0", flags, mem_addr, mem_wdata, mem_be);
        end
        #1 rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (flags !== 5'b01000) begin
                bad++;
                $display("FAIL rmid_after%0d: flags got %b want 01000", i, flags);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        int gap;
        for (int i = 0; i < 40; i++) begin
            do_store(2'($urandom), $urandom, $urandom, $urandom_range(0, TO + 1), "rand");
            gap = $urandom_range(1, 2);
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'($urandom);
                tick();
                total++;
                if (flags !== 5'b01000) begin
                    bad++;
                    $display("FAIL rand_gap%0d: flags got %b want 01000", i, flags);
                end
            end
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_ack_idle();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
